rpn_tokenizer: RTL and testbench

RPN_TOKENIZER -- requirements
Module: rpn_tokenizer

---
 rtl/rpn_tokenizer.sv | 184 ++++++++++++++++++
 tb/tb_rpn_tokenizer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_tokenizer.sv
// Byte-stream tokenizer for RPN expressions: numbers, operators and end-of-line into a FWFT token FIFO.
// Define RPN_TOK_OVF_SAT_EN to saturate the number accumulator on overflow instead of wrapping.
module rpn_tokenizer #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    output logic              tok_valid,
    input  logic              tok_ready,
    output logic [1:0]        tok_kind,
    output logic [DATA_W-1:0] tok_value,
    output logic              err_char,
    output logic              err_drop,
    output logic              ovf
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned AW = DATA_W + 4;

    localparam logic [1:0] K_NUM = 2'b00;
    localparam logic [1:0] K_OP  = 2'b01;
    localparam logic [1:0] K_EOL = 2'b10;

    typedef enum logic [1:0] {IDLE, NUM, PEND} state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] acc, acc_n;
    logic [1:0]        pend_kind, pend_kind_n;
    logic [DATA_W-1:0] pend_value, pend_value_n;
    logic              ovf_q, ovf_set;
    logic              err_char_q, err_drop_q;
    logic              bad_char, byte_drop;

    logic              push;
    logic [1:0]        push_kind;
    logic [DATA_W-1:0] push_value;

    logic              is_digit, is_sep, is_op, is_lf;
    logic [AW-1:0]     mac;
    logic              mac_ovf;

    logic [1:0]        mem_kind  [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_value [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              full, pop, push_ok, push_lost;

    assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign is_sep   = (rx_data == 8'h20) || (rx_data == 8'h0D);
    assign is_op    = (rx_data == 8'h2B) || (rx_data == 8'h2D) ||
                      (rx_data == 8'h2A) || (rx_data == 8'h2F);
    assign is_lf    = (rx_data == 8'h0A);

    // Full-width multiply-accumulate so overflow is judged on the untruncated result.
    assign mac     = AW'(acc) * AW'(10) + AW'(rx_data[3:0]);
    assign mac_ovf = |mac[AW-1:DATA_W];

    always_comb begin
        state_n      = state;
        acc_n        = acc;
        pend_kind_n  = pend_kind;
        pend_value_n = pend_value;
        ovf_set      = 1'b0;
        bad_char     = 1'b0;
        byte_drop    = 1'b0;
        push         = 1'b0;
        push_kind    = K_NUM;
        push_value   = '0;
        case (state)
            PEND: begin
                push       = 1'b1;
                push_kind  = pend_kind;
                push_value = pend_value;
                byte_drop  = rx_ready;
                state_n    = IDLE;
            end
            NUM: begin
                if (rx_ready) begin
                    if (is_digit) begin
                        ovf_set = mac_ovf;
`ifdef RPN_TOK_OVF_SAT_EN
                        acc_n = mac_ovf ? '1 : mac[DATA_W-1:0];
`else
                        acc_n = mac[DATA_W-1:0];
`endif
                    end else if (is_sep) begin
                        push       = 1'b1;
                        push_value = acc;
                        acc_n      = '0;
                        state_n    = IDLE;
                    end else if (is_op || is_lf) begin
                        push         = 1'b1;
                        push_value   = acc;
                        acc_n        = '0;
                        pend_kind_n  = is_lf ? K_EOL : K_OP;
                        pend_value_n = is_lf ? '0 : DATA_W'(rx_data);
                        state_n      = PEND;
                    end else begin
                        bad_char = 1'b1;
                        acc_n    = '0;
                        state_n  = IDLE;
                    end
                end
            end
            default: begin
                if (rx_ready) begin
                    if (is_digit) begin
                        acc_n   = DATA_W'(rx_data[3:0]);
                        state_n = NUM;
                    end else if (is_op || is_lf) begin
                        push       = 1'b1;
                        push_kind  = is_lf ? K_EOL : K_OP;
                        push_value = is_lf ? '0 : DATA_W'(rx_data);
                    end else if (!is_sep) begin
                        bad_char = 1'b1;
                        acc_n    = '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= '0;
            pend_kind  <= K_NUM;
            pend_value <= '0;
            ovf_q      <= 1'b0;
            err_char_q <= 1'b0;
            err_drop_q <= 1'b0;
        end else begin
            state      <= state_n;
            acc        <= acc_n;
            pend_kind  <= pend_kind_n;
            pend_value <= pend_value_n;
            ovf_q      <= ovf_q | ovf_set;
            err_char_q <= bad_char;
            err_drop_q <= byte_drop | push_lost;
        end
    end

    // A full FIFO still accepts a push when the head is popped on the same edge.
    assign full      = (count == CW'(FIFO_DEPTH));
    assign pop       = tok_valid && tok_ready;
    assign push_ok   = push && (!full || pop);
    assign push_lost = push && full && !pop;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_kind[wr_ptr]  <= push_kind;
            mem_value[wr_ptr] <= push_value;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push_ok && !pop)
                count <= count + CW'(1);
            else if (pop && !push_ok)
                count <= count - CW'(1);
        end
    end

    assign tok_valid = (count != '0);
    assign tok_kind  = tok_valid ? mem_kind[rd_ptr]  : 2'b00;
    assign tok_value = tok_valid ? mem_value[rd_ptr] : '0;
    assign err_char  = err_char_q;
    assign err_drop  = err_drop_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_rpn_tokenizer.sv
// Directed bench for rpn_tokenizer: table of byte strings with expected tokens, plus timing/FIFO/reset sequences.
module tb_rpn_tokenizer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tok_valid;
    logic        tok_ready;
    logic [1:0]  tok_kind;
    logic [15:0] tok_value;
    logic        err_char;
    logic        err_drop;
    logic        ovf;

    rpn_tokenizer #(.DATA_W(16), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .tok_valid (tok_valid),
        .tok_ready (tok_ready),
        .tok_kind  (tok_kind),
        .tok_value (tok_value),
        .err_char  (err_char),
        .err_drop  (err_drop),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    typedef struct {
        string             s;
        int unsigned       ntok;
        logic [3:0][17:0]  toks;
        int unsigned       ec;
        int unsigned       ed;
        logic              ovf;
    } vec_t;

    vec_t        vt[$];
    logic [17:0] got_q[$];
    int unsigned ec_cnt;
    int unsigned ed_cnt;
    int unsigned total;
    int unsigned bad;

`ifdef RPN_TOK_OVF_SAT_EN
    localparam logic [15:0] V70000 = 16'd65535;
    localparam logic [15:0] V65536 = 16'd65535;
`else
    localparam logic [15:0] V70000 = 16'd4464;
    localparam logic [15:0] V65536 = 16'd0;
`endif

    // Tokens are recorded on the falling edge preceding the pop edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tok_valid && tok_ready)
                got_q.push_back({tok_kind, tok_value});
            if (err_char)
                ec_cnt++;
            if (err_drop)
                ed_cnt++;
        end
    end

    function automatic logic [17:0] tk(input logic [1:0] k, input logic [15:0] v);
        return {k, v};
    endfunction

    task automatic add_vec(input string s, input int unsigned n,
                           input logic [17:0] t0, input logic [17:0] t1,
                           input logic [17:0] t2, input logic [17:0] t3,
                           input int unsigned ec, input int unsigned ed, input logic o);
        vec_t v;
        v.s       = s;
        v.ntok    = n;
        v.toks[0] = t0;
        v.toks[1] = t1;
        v.toks[2] = t2;
        v.toks[3] = t3;
        v.ec      = ec;
        v.ed      = ed;
        v.ovf     = o;
        vt.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        rx_ready = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        got_q.delete();
        ec_cnt = 0;
        ed_cnt = 0;
    endtask

    task automatic send_now(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1;
        send_now(b);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++)
            send(s[i]);
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_tokens(input string name, input int unsigned n, input logic [3:0][17:0] exp);
        logic [17:0] g;
        chk({name, ".ntok"}, got_q.size(), n);
        for (int i = 0; i < int'(n); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 18'h3FFFF;
            chk($sformatf("%s.tok%0d", name, i), {14'd0, g}, {14'd0, exp[i]});
        end
    endtask

    initial begin
        logic [3:0][17:0] e;
        total     = 0;
        bad       = 0;
        ec_cnt    = 0;
        ed_cnt    = 0;
        tok_ready = 1'b1;

        add_vec("12 34+\n", 4, tk(0, 12), tk(0, 34), tk(1, 16'h2B), tk(2, 0), 0, 0, 1'b0);
        add_vec("5a3 ",     1, tk(0, 3), '0, '0, '0, 1, 0, 1'b0);
        add_vec("70000 ",   1, tk(0, V70000), '0, '0, '0, 0, 0, 1'b1);
        add_vec("8/ 9-\r",  4, tk(0, 8), tk(1, 16'h2F), tk(0, 9), tk(1, 16'h2D), 0, 0, 1'b0);
        add_vec("\n-0 ",    3, tk(2, 0), tk(1, 16'h2D), tk(0, 0), '0, 0, 0, 1'b0);
        add_vec("65535 ",   1, tk(0, 16'd65535), '0, '0, '0, 0, 0, 1'b0);
        add_vec("65536 ",   1, tk(0, V65536), '0, '0, '0, 0, 0, 1'b1);

        // Reset values, sampled while reset is held.
        rst_n    = 1'b0;
        rx_ready = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.tok_valid", {31'd0, tok_valid}, 0);
        chk("rst.tok_kind",  {30'd0, tok_kind}, 0);
        chk("rst.tok_value", {16'd0, tok_value}, 0);
        chk("rst.err_char",  {31'd0, err_char}, 0);
        chk("rst.err_drop",  {31'd0, err_drop}, 0);
        chk("rst.ovf",       {31'd0, ovf}, 0);

        foreach (vt[k]) begin
            do_reset();
            send_str(vt[k].s);
            idle(6);
            chk_tokens($sformatf("vec%0d", k), vt[k].ntok, vt[k].toks);
            chk($sformatf("vec%0d.err_char", k), ec_cnt, vt[k].ec);
            chk($sformatf("vec%0d.err_drop", k), ed_cnt, vt[k].ed);
            chk($sformatf("vec%0d.ovf", k), {31'd0, ovf}, {31'd0, vt[k].ovf});
        end

        // "7*": number valid one cycle after '*', operator one cycle later; push+pop at count 1.
        do_reset();
        send("7");
        send_now("*");
        @(negedge clk);
        chk("t7.num_valid", {31'd0, tok_valid}, 1);
        chk("t7.num_tok", {14'd0, tok_kind, tok_value}, {14'd0, tk(0, 7)});
        @(negedge clk);
        chk("t7.op_valid", {31'd0, tok_valid}, 1);
        chk("t7.op_tok", {14'd0, tok_kind, tok_value}, {14'd0, tk(1, 16'h2A)});
        @(negedge clk);
        chk("t7.empty_valid", {31'd0, tok_valid}, 0);
        chk("t7.empty_tok", {14'd0, tok_kind, tok_value}, 0);

        // Six numbers into a four-entry FIFO with the consumer stalled.
        do_reset();
        tok_ready = 1'b0;
        send_str("1 2 3 4 5 6 ");
        idle(2);
        chk("full.err_drop", ed_cnt, 2);
        chk("full.valid", {31'd0, tok_valid}, 1);
        tok_ready = 1'b1;
        idle(6);
        e = {tk(0, 4), tk(0, 3), tk(0, 2), tk(0, 1)};
        chk_tokens("full", 4, e);

        // Push into a full FIFO on the same edge as a pop is accepted.
        do_reset();
        tok_ready = 1'b0;
        send_str("1 2 3 4 5");
        @(posedge clk);
        #1;
        tok_ready = 1'b1;
        send_now(" ");
        idle(8);
        chk("fullpop.err_drop", ed_cnt, 0);
        chk("fullpop.ntok", got_q.size(), 5);
        chk("fullpop.last", (got_q.size() == 5) ? {14'd0, got_q[4]} : 32'hFFFF_FFFF, {14'd0, tk(0, 5)});

        // Byte arriving during PEND is dropped; pending operator still emitted.
        do_reset();
        send("7");
        send_now("+");
        send_now("9");
        send(" ");
        idle(4);
        chk("pend.err_drop", ed_cnt, 1);
        chk("pend.err_char", ec_cnt, 0);
        e = {18'd0, 18'd0, tk(1, 16'h2B), tk(0, 7)};
        chk_tokens("pend", 2, e);

        // Reset after "98" discards the partial number.
        do_reset();
        send_str("98");
        idle(1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_str("1 ");
        idle(4);
        e = {18'd0, 18'd0, 18'd0, tk(0, 1)};
        chk_tokens("rstnum", 1, e);

        // Reset landing on the PEND edge discards both number and operator.
        do_reset();
        tok_ready = 1'b0;
        send("4");
        send_now("+");
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        tok_ready = 1'b1;
        idle(4);
        chk("rstpend.ntok", got_q.size(), 0);
        chk("rstpend.valid", {31'd0, tok_valid}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
